// File: rtl/arm_cond_pkg.sv
// Shared definitions for the ARMv4 condition-execution unit: condition codes,
// flag bit positions inside the {N,Z,C,V} vector and flag_write bit positions.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside flag_write: NZ half and CV half.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit ARM condition code against the
// current {N,Z,C,V} flags.
module cond_check
    import arm_cond_pkg::*;
(
    input  cond_t      cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition table lookup; NV never passes.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition-execution unit: owns the architectural NZCV flags, gates the
// execute-stage side effects by the condition result, registers the gated
// controls into the execute/memory boundary and counts executed and
// condition-skipped instructions with saturating counters.
// No handshake: the stage advances on every cycle in which stall_e is low;
// stall_e freezes all state, flush_e turns the current instruction into a
// bubble, reset overrides both.
module cond_unit
    import arm_cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_write_e,
    input  logic [3:0]       alu_flags_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             pc_src_e,
    output logic             cond_ex_e,
    output logic [3:0]       flags,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic             pc_src_m,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic live;
    logic pass;

    cond_check u_cond_check (
        .cond  (cond_t'(cond_e)),
        .flags (flags),
        .pass  (pass)
    );

    // An instruction only counts as live when it is valid, not squashed and
    // actually leaving the stage this cycle.
    assign live      = valid_e & !flush_e & !stall_e;
    assign cond_ex_e = live & pass;

    // Flag register: each half loads independently from the ALU result of an
    // executed instruction; no bypass, so the next instruction sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (cond_ex_e) begin
            if (flag_write_e[FW_NZ]) begin
                flags[FLAG_N:FLAG_Z] <= alu_flags_e[FLAG_N:FLAG_Z];
            end
            if (flag_write_e[FW_CV]) begin
                flags[FLAG_C:FLAG_V] <= alu_flags_e[FLAG_C:FLAG_V];
            end
        end
    end

    // Execute/memory boundary register for the gated controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
        end else if (!stall_e) begin
            if (flush_e) begin
                reg_write_m <= 1'b0;
                mem_write_m <= 1'b0;
                pc_src_m    <= 1'b0;
            end else begin
                reg_write_m <= reg_write_e & cond_ex_e;
                mem_write_m <= mem_write_e & cond_ex_e;
                pc_src_m    <= pc_src_e & cond_ex_e;
            end
        end
    end

    // Saturating executed / skipped instruction counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_count <= '0;
            skip_count <= '0;
        end else begin
            if (cond_ex_e && (exec_count != CNT_MAX)) begin
                exec_count <= exec_count + 1'b1;
            end
            if (live && !pass && (skip_count != CNT_MAX)) begin
                skip_count <= skip_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed vector table from the test plan, a randomized
// phase checked against a behavioural model, counter saturation and a
// mid-stream reset.
module tb_cond_unit;

    localparam int CNT_W = 16;
    localparam int SW    = 4 + 3 + 2 * CNT_W;

    logic             clk;
    logic             reset;
    logic             stall_e;
    logic             flush_e;
    logic             valid_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_write_e;
    logic [3:0]       alu_flags_e;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             pc_src_e;
    logic             cond_ex_e;
    logic [3:0]       flags;
    logic             reg_write_m;
    logic             mem_write_m;
    logic             pc_src_m;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .valid_e      (valid_e),
        .cond_e       (cond_e),
        .flag_write_e (flag_write_e),
        .alu_flags_e  (alu_flags_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .pc_src_e     (pc_src_e),
        .cond_ex_e    (cond_ex_e),
        .flags        (flags),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .pc_src_m     (pc_src_m),
        .exec_count   (exec_count),
        .skip_count   (skip_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec    = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] exp_q[$];

    typedef struct {
        logic       s, f, v;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       rw, mw, ps;
        logic       e_cex;
        logic [3:0] e_flags;
        logic       e_rw, e_mw, e_ps;
        int         e_exec, e_skip;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state for the random phase.
    logic [3:0]       m_flags;
    logic             m_rw, m_mw, m_ps;
    logic [CNT_W-1:0] m_exec, m_skip;

    function automatic vec_t mk(logic s, logic f, logic v, logic [3:0] cond,
                                logic [1:0] fw, logic [3:0] alu,
                                logic rw, logic mw, logic ps, logic e_cex,
                                logic [3:0] e_flags, logic e_rw, logic e_mw,
                                logic e_ps, int e_exec, int e_skip);
        vec_t t;
        t.s = s; t.f = f; t.v = v; t.cond = cond; t.fw = fw; t.alu = alu;
        t.rw = rw; t.mw = mw; t.ps = ps; t.e_cex = e_cex; t.e_flags = e_flags;
        t.e_rw = e_rw; t.e_mw = e_mw; t.e_ps = e_ps;
        t.e_exec = e_exec; t.e_skip = e_skip;
        return t;
    endfunction

    function automatic logic [SW-1:0] pack_state(logic [3:0] fl, logic rw,
                                                  logic mw, logic ps,
                                                  logic [CNT_W-1:0] ex,
                                                  logic [CNT_W-1:0] sk);
        return {fl, rw, mw, ps, ex, sk};
    endfunction

    // ARM encoding view: cond[3:1] selects a base test, cond[0] inverts it.
    function automatic logic model_pass(logic [3:0] cond, logic [3:0] fl);
        logic n, z, c, v, b;
        n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
        case (cond[3:1])
            3'd0:    b = z;
            3'd1:    b = c;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = c && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return cond[0] ? !b : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; valid_e = 1'b0;
        cond_e = 4'd0; flag_write_e = 2'd0; alu_flags_e = 4'd0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; pc_src_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_m", 32'({reg_write_m, mem_write_m, pc_src_m}), 32'h0);
        check("reset_exec", 32'(exec_count), 32'h0);
        check("reset_skip", 32'(skip_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'd0; m_rw = 1'b0; m_mw = 1'b0; m_ps = 1'b0;
        m_exec = '0; m_skip = '0;
    endtask

    // Driver: apply one cycle of stimulus, check the combinational result,
    // queue the expected post-edge state and compare it after the edge.
    task automatic apply(input vec_t t, input logic [SW-1:0] e_state,
                         input string tag);
        logic [SW-1:0] e;
        @(negedge clk);
        stall_e = t.s; flush_e = t.f; valid_e = t.v; cond_e = t.cond;
        flag_write_e = t.fw; alu_flags_e = t.alu;
        reg_write_e = t.rw; mem_write_e = t.mw; pc_src_e = t.ps;
        exp_q.push_back(e_state);
        n_vec++;
        #1;
        check({tag, "_cond_ex"}, 32'(cond_ex_e), 32'(t.e_cex));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_flags"}, 32'(flags), 32'(e[SW-1 -: 4]));
        check({tag, "_reg_write_m"}, 32'(reg_write_m), 32'(e[2*CNT_W+2]));
        check({tag, "_mem_write_m"}, 32'(mem_write_m), 32'(e[2*CNT_W+1]));
        check({tag, "_pc_src_m"}, 32'(pc_src_m), 32'(e[2*CNT_W]));
        check({tag, "_exec_count"}, 32'(exec_count), 32'(e[2*CNT_W-1 -: CNT_W]));
        check({tag, "_skip_count"}, 32'(skip_count), 32'(e[CNT_W-1:0]));
    endtask

    // Advance the behavioural model by one cycle; returns expected cond_ex.
    task automatic model_step(input vec_t t, output logic cex);
        logic live, p;
        live = t.v && !t.f && !t.s;
        p    = model_pass(t.cond, m_flags);
        cex  = live && p;
        if (cex && t.fw[1]) m_flags[3:2] = t.alu[3:2];
        if (cex && t.fw[0]) m_flags[1:0] = t.alu[1:0];
        if (!t.s) begin
            m_rw = t.rw && cex && !t.f;
            m_mw = t.mw && cex && !t.f;
            m_ps = t.ps && cex && !t.f;
        end
        if (cex && m_exec != {CNT_W{1'b1}}) m_exec = m_exec + 1'b1;
        if (live && !p && m_skip != {CNT_W{1'b1}}) m_skip = m_skip + 1'b1;
    endtask

    initial begin
        vec_t t;
        logic cex;

        reset = 1'b1;
        // Directed table:   s  f  v  cond     fw     alu      rw mw ps cex  flags   rwm mwm psm exec skip
        vecs.push_back(mk(0, 0, 1, 4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));  // EQ skipped
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 1, 1));  // AL set Z
        vecs.push_back(mk(0, 0, 1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 1, 4'b0100, 0, 1, 0, 2, 1));  // EQ passes
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 3, 1));  // N=1 V=0
        vecs.push_back(mk(0, 0, 1, 4'b1010, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1000, 0, 0, 0, 3, 2));  // GE fails
        vecs.push_back(mk(0, 0, 1, 4'b1011, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b1000, 1, 0, 0, 4, 2));  // LT passes
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 5, 2));  // Z=1
        vecs.push_back(mk(0, 0, 1, 4'b1100, 2'b00, 4'b0000, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 5, 3));  // GT fails
        vecs.push_back(mk(0, 0, 1, 4'b1101, 2'b00, 4'b0000, 0, 0, 1, 1, 4'b0100, 0, 0, 1, 6, 3));  // LE passes
        vecs.push_back(mk(0, 0, 1, 4'b1111, 2'b11, 4'b1111, 1, 1, 1, 0, 4'b0100, 0, 0, 0, 6, 4));  // NV skipped
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 1, 4'b1111, 0, 0, 0, 7, 4));  // flags=1111
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b10, 4'b0000, 0, 0, 0, 1, 4'b0011, 0, 0, 0, 8, 4));  // NZ half only
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b01, 4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 9, 4));  // CV half only
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b00, 4'b0000, 1, 1, 0, 1, 4'b0000, 1, 1, 0, 10, 4)); // load M
        vecs.push_back(mk(1, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 4'b0000, 1, 1, 0, 10, 4)); // stall 1
        vecs.push_back(mk(1, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 4'b0000, 1, 1, 0, 10, 4)); // stall 2
        vecs.push_back(mk(1, 0, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 4'b0000, 1, 1, 0, 10, 4)); // stall 3
        vecs.push_back(mk(1, 1, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 4'b0000, 1, 1, 0, 10, 4)); // stall+flush
        vecs.push_back(mk(0, 1, 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 10, 4)); // flush AL
        vecs.push_back(mk(0, 0, 0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 10, 4)); // bubble
        vecs.push_back(mk(0, 0, 1, 4'b0000, 2'b11, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 10, 5)); // skip w/ fw
        vecs.push_back(mk(0, 0, 1, 4'b0010, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 10, 6)); // CS fails
        vecs.push_back(mk(0, 0, 1, 4'b0011, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b0000, 1, 0, 0, 11, 6)); // CC passes
        vecs.push_back(mk(0, 0, 1, 4'b1110, 2'b11, 4'b0010, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 12, 6)); // C=1
        vecs.push_back(mk(0, 0, 1, 4'b1000, 2'b00, 4'b0000, 0, 0, 1, 1, 4'b0010, 0, 0, 1, 13, 6)); // HI passes
        vecs.push_back(mk(0, 0, 1, 4'b1001, 2'b00, 4'b0000, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 13, 7)); // LS fails
        vecs.push_back(mk(0, 0, 1, 4'b0100, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0010, 0, 0, 0, 13, 8)); // MI fails
        vecs.push_back(mk(0, 0, 1, 4'b0101, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b0010, 1, 0, 0, 14, 8)); // PL passes
        vecs.push_back(mk(0, 0, 1, 4'b0110, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0010, 0, 0, 0, 14, 9)); // VS fails
        vecs.push_back(mk(0, 0, 1, 4'b0111, 2'b00, 4'b0000, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 15, 9)); // VC passes
        vecs.push_back(mk(0, 0, 1, 4'b0001, 2'b00, 4'b0000, 0, 1, 0, 1, 4'b0010, 0, 1, 0, 16, 9)); // NE passes

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i], pack_state(vecs[i].e_flags, vecs[i].e_rw, vecs[i].e_mw,
                                      vecs[i].e_ps, CNT_W'(vecs[i].e_exec),
                                      CNT_W'(vecs[i].e_skip)), "dir");
        end

        // Randomized traffic against the behavioural model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            t = mk($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0);
            model_step(t, cex);
            t.e_cex = cex;
            apply(t, pack_state(m_flags, m_rw, m_mw, m_ps, m_exec, m_skip), "rnd");
        end

        // Saturation: 2^CNT_W passing instructions leave exec_count at all-ones.
        do_reset();
        @(negedge clk);
        valid_e = 1'b1; cond_e = 4'b1110; flag_write_e = 2'b11;
        alu_flags_e = 4'b1010; reg_write_e = 1'b1;
        repeat (1 << CNT_W) @(posedge clk);
        #1;
        check("sat_exec", 32'(exec_count), 32'(16'hFFFF));
        check("sat_skip", 32'(skip_count), 32'h0);
        check("sat_flags", 32'(flags), 32'hA);
        check("sat_reg_write_m", 32'(reg_write_m), 32'h1);
        @(posedge clk);
        #1;
        check("sat_nowrap", 32'(exec_count), 32'(16'hFFFF));
        n_vec += (1 << CNT_W) + 1;

        // Reset mid-stream with stall and flush also asserted.
        @(negedge clk);
        reset = 1'b1; stall_e = 1'b1; flush_e = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_flags", 32'(flags), 32'h0);
        check("midrst_m", 32'({reg_write_m, mem_write_m, pc_src_m}), 32'h0);
        check("midrst_exec", 32'(exec_count), 32'h0);
        check("midrst_skip", 32'(skip_count), 32'h0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-execution unit for the ARMv4 pipeline. It holds the architectural NZCV flags and evaluates each execute-stage instruction's 4-bit condition field against them. It gates the instruction's side effects (register write, memory write, PC redirect, flag update) and registers the gated controls into the execute/memory boundary. It is the consumer side of the CPSR flag interface and keeps saturating counters of executed and condition-skipped instructions.

## Interface
Parameters:
- CNT_W, 16, width of the executed/skipped instruction counters.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high.
- stall_e  in  1  execute stage held; no state changes this cycle.
- flush_e  in  1  execute-stage instruction squashed; becomes a bubble.
- valid_e  in  1  execute stage holds a real instruction.
- cond_e  in  4  instruction condition field (bits 31:28).
- flag_write_e  in  2  [1] update N,Z; [0] update C,V.
- alu_flags_e  in  4  {N,Z,C,V} produced by the ALU this cycle.
- reg_write_e, mem_write_e, pc_src_e  in  1 each  ungated decoder controls.
- cond_ex_e  out  1  combinational: condition passed and instruction live.
- flags  out  4  current {N,Z,C,V} register.
- reg_write_m, mem_write_m, pc_src_m  out  1 each  registered gated controls.
- exec_count, skip_count  out  CNT_W  saturating counters.

## Operation
- Condition table (N,Z,C,V from `flags`):
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N. 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z. 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V). 1110 AL: 1. 1111 NV: 0.
- live = valid_e & !flush_e & !stall_e. cond_ex_e = live & pass(cond_e, flags).
- Flags update when cond_ex_e is high:
  - flag_write_e[1] loads flags[3:2] from alu_flags_e[3:2].
  - flag_write_e[0] loads flags[1:0] from alu_flags_e[1:0].
  - Each half updates independently.
- M registers:
  - When !stall_e, load reg_write_e&cond_ex_e, mem_write_e&cond_ex_e and pc_src_e&cond_ex_e.
  - When stall_e, they hold.
  - flush_e with !stall_e loads zeros.
- Counters: exec_count increments on cond_ex_e; skip_count increments on live & !pass. Both saturate at all-ones with no wrap.

## Timing
- Condition evaluation is combinational in the same cycle. Flags written by an instruction are visible to the next instruction one cycle later; there is no same-cycle flag bypass.
- Gated controls appear at the *_m outputs 1 cycle after the execute cycle.
- Reset values: flags=0000, reg_write_m=mem_write_m=pc_src_m=0, exec_count=skip_count=0. Reset overrides stall_e and flush_e. Reset mid-stream discards in-flight controls.
- Priority when signals coincide: reset > stall_e > flush_e > normal. With stall_e&flush_e, everything holds; flush takes effect on the first unstalled cycle if still asserted.
- valid_e=0 is a bubble: *_m load 0 (if not stalled), flags and counters unchanged.
- A skipped instruction with flag_write_e set leaves flags unchanged.

## Structure
- Package arm_cond_pkg holds:
  - the cond_t enum for the 16 codes;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the flag_write bit indices.
- Sub-module cond_check is purely combinational: (cond_t, flags) -> pass. cond_unit instantiates it once.
- cond_unit owns the flag register, the M pipeline register and the counters.

## Test plan
- After reset: flags=0000. Issue cond=0000 (EQ), reg_write_e=1 -> cond_ex_e=0, reg_write_m=0 next cycle, skip_count=1.
- Issue alu_flags=0100, flag_write=11, cond=1110 -> flags=0100 next cycle. Then EQ with mem_write_e=1 -> mem_write_m=1, exec_count=2.
- Signed compares: flags N=1,V=0 -> GE fails, LT passes. Flags Z=1 -> GT fails, LE passes. cond=1111 is always skipped.
- Partial flag write: flags=1111, alu_flags=0000, flag_write=10 -> flags=0011. Then flag_write=01 -> flags=0000.
- Hold and squash: stall_e=1 for 3 cycles while an instruction is valid -> *_m, flags and counters held. flush_e=1 with a passing AL pc_src_e=1 -> pc_src_m=0, flags unchanged, no count.
- Saturation: preload by running 2^CNT_W passing instructions -> exec_count stays 0xFFFF. Assert reset mid-run -> all outputs 0 next cycle.
